// File: rtl/mem_arb.sv
// -----------------------------------------------------------------------------
// mem_arb -- arbiter/sequencer for the single-ported unified memory shared by
// the instruction-fetch port (IF stage) and the data port (MEM stage).
//
// One transaction at a time: IDLE picks a winner (data always beats IF) and
// registers the address/write data, ISSUE strobes mem_en for exactly one
// cycle, WAIT counts down the fixed read latency and captures mem_rdata, and
// RESP pulses the winner's ready for one cycle. Writes skip WAIT.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-low reset
//   if_req/if_addr           fetch request (held until if_ready) and address
//   if_rdata/if_ready        fetched word and one-cycle completion pulse
//   d_re/d_we/d_addr/d_wdata data request (held until d_ready); both high = write
//   d_rdata/d_ready          read data and one-cycle completion pulse
//   mem_en/mem_we            memory strobe (one cycle per transaction) + write
//   mem_addr/mem_wdata       registered address / write data to the memory
//   mem_rdata                memory read data, valid LAT cycles after mem_en
//   stall_if/stall_pipe      combinational stalls while a port waits
//
// Parameters: LAT (read latency, 1..15), AW (address width).
//
// Optional feature (macro MEM_ARB_PERF_EN): adds if_wait_cnt[15:0] and
// d_wait_cnt[15:0], saturating counts of cycles spent with stall_if /
// stall_pipe asserted.
// -----------------------------------------------------------------------------
module mem_arb #(
  parameter int LAT = 2,
  parameter int AW  = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [31:0]   if_rdata,
  output logic          if_ready,
  input  logic          d_re,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic [31:0]   d_rdata,
  output logic          d_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          stall_if,
  output logic          stall_pipe
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [15:0]   if_wait_cnt,
  output logic [15:0]   d_wait_cnt
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  // LAT is limited to 1..15, so a 4-bit down-counter covers it.
  localparam logic [3:0] LAT_CNT = 4'(LAT);

  logic [1:0] state;
  logic       owner_d;   // 1: data port owns the transaction, 0: IF port
  logic [3:0] lat_cnt;
  logic       d_pend;

  assign d_pend = d_re | d_we;

  // Strobes and pulses decode straight from the state register, so they are
  // glitch-free and fall to 0 the instant reset asserts.
  assign mem_en   = (state == S_ISSUE);
  assign if_ready = (state == S_RESP) & ~owner_d;
  assign d_ready  = (state == S_RESP) &  owner_d;

  assign stall_if   = if_req & ~if_ready;
  assign stall_pipe = d_pend & ~d_ready;

  // NOTE: sequential state uses non-blocking (<=) assignments only, so every
  // flop samples the pre-edge value of its inputs regardless of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      owner_d   <= 1'b0;
      lat_cnt   <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // Data wins any simultaneous request; IF only goes when the data
          // port is quiet.
          if (d_pend) begin
            owner_d   <= 1'b1;
            mem_addr  <= d_addr;
            mem_we    <= d_we;
            mem_wdata <= d_wdata;
            state     <= S_ISSUE;
          end else if (if_req) begin
            owner_d  <= 1'b0;
            mem_addr <= if_addr;
            mem_we   <= 1'b0;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (mem_we) begin
            state <= S_RESP;
          end else begin
            lat_cnt <= LAT_CNT;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          lat_cnt <= lat_cnt - 4'd1;
          // Counter value 1 marks the cycle LAT after mem_en, when the
          // memory presents its data.
          if (lat_cnt == 4'd1) begin
            if (owner_d) d_rdata  <= mem_rdata;
            else         if_rdata <= mem_rdata;
            state <= S_RESP;
          end
        end
        S_RESP: begin
          // Requests are not sampled here: a request still held during its
          // own ready cycle must not be issued a second time.
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_wait_cnt <= '0;
      d_wait_cnt  <= '0;
    end else begin
      if (stall_if && (if_wait_cnt != 16'hFFFF))
        if_wait_cnt <= if_wait_cnt + 16'd1;
      if (stall_pipe && (d_wait_cnt != 16'hFFFF))
        d_wait_cnt <= d_wait_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arb.sv
// -----------------------------------------------------------------------------
// tb_mem_arb -- self-checking bench for mem_arb.
// Every request pushes its expected memory access and completion onto
// scoreboard queues; a negedge monitor pops and compares them as mem_en and
// the ready pulses appear. The bench also models the memory (fixed LAT read
// latency, garbage on mem_rdata outside the valid cycle).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_arb;

  localparam int LAT = 2;
  localparam int AW  = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [31:0]   if_rdata;
  logic          if_ready;
  logic          d_re = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [31:0]   d_wdata = '0;
  logic [31:0]   d_rdata;
  logic          d_ready;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;
  logic          stall_if;
  logic          stall_pipe;
`ifdef MEM_ARB_PERF_EN
  logic [15:0]   if_wait_cnt;
  logic [15:0]   d_wait_cnt;
`endif

  mem_arb #(.LAT(LAT), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_ready   (if_ready),
    .d_re       (d_re),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_ready    (d_ready),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .stall_if   (stall_if),
    .stall_pipe (stall_pipe)
`ifdef MEM_ARB_PERF_EN
    ,
    .if_wait_cnt(if_wait_cnt),
    .d_wait_cnt (d_wait_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic        port_if;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          en_cyc;
    int          rdy_cyc;
  } txn_t;

  txn_t        en_q[$];
  txn_t        rdy_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] dut_mem [logic [31:0]];

  int          n_vec = 0;
  int          n_err = 0;
  bit          sb_on = 1'b0;
  int          en_cnt = 0;
  int          rdy_cnt = 0;
  int          stall_if_cyc = 0;
  int          stall_pipe_cyc = 0;
  int          mem_cd = 0;
  logic [31:0] lat_addr = '0;

  function automatic logic [31:0] fill(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'h3C00_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic port_if, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input int en_c, input int rdy_c,
                      input bit want_rdy);
    txn_t t;
    t.port_if = port_if;
    t.we      = we;
    t.addr    = addr;
    t.wdata   = wdata;
    t.en_cyc  = en_c;
    t.rdy_cyc = rdy_c;
    if (we) ref_mem[addr] = wdata;
    t.rdata = we ? 32'h0 : (ref_mem.exists(addr) ? ref_mem[addr] : fill(addr));
    en_q.push_back(t);
    if (want_rdy) rdy_q.push_back(t);
  endtask

  // Memory model and scoreboard monitor, both evaluated mid-cycle.
  always @(negedge clk) begin
    txn_t e;
    mem_rdata = 32'hBAD0_0000 | (32'(cyc) & 32'h0000_FFFF);
    if (mem_cd > 0) begin
      mem_cd--;
      if (mem_cd == 0)
        mem_rdata = dut_mem.exists(lat_addr) ? dut_mem[lat_addr] : fill(lat_addr);
    end
    if (mem_en) begin
      en_cnt++;
      if (mem_we) dut_mem[mem_addr] = mem_wdata;
      else begin
        mem_cd   = LAT;
        lat_addr = mem_addr;
      end
      if (sb_on) begin
        if (en_q.size() == 0) check("en_unexpected", 32'd1, 32'd0);
        else begin
          e = en_q.pop_front();
          check("en_cycle", cyc, e.en_cyc);
          check("en_we", {31'd0, mem_we}, {31'd0, e.we});
          check("en_addr", mem_addr, e.addr);
          if (e.we) check("en_wdata", mem_wdata, e.wdata);
        end
      end
    end
    if (stall_if)   stall_if_cyc++;
    if (stall_pipe) stall_pipe_cyc++;
    if (if_ready || d_ready) begin
      rdy_cnt++;
      if (sb_on) begin
        check("rdy_both", {31'd0, if_ready & d_ready}, 32'd0);
        if (rdy_q.size() == 0) check("rdy_unexpected", 32'd1, 32'd0);
        else begin
          e = rdy_q.pop_front();
          check("rdy_port_if", {31'd0, if_ready}, {31'd0, e.port_if});
          check("rdy_cycle", cyc, e.rdy_cyc);
          if (!e.we) check("rdy_rdata", e.port_if ? if_rdata : d_rdata, e.rdata);
        end
      end
    end
  end

  // Requesters hold their request through the ready cycle, then drop it.
  task automatic drive_if(input logic [31:0] a);
    if_req  = 1'b1;
    if_addr = a;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (if_ready) begin
        tick();
        if_req = 1'b0;
        return;
      end
    end
    check("if_timeout", 32'd0, 32'd1);
    if_req = 1'b0;
  endtask

  task automatic drive_d(input logic re, input logic we, input logic [31:0] a,
                         input logic [31:0] wd);
    d_re    = re;
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (d_ready) begin
        tick();
        d_re = 1'b0;
        d_we = 1'b0;
        return;
      end
    end
    check("d_timeout", 32'd0, 32'd1);
    d_re = 1'b0;
    d_we = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  // Simultaneous IF and data read: data first, IF served afterwards.
  task automatic run_scen2();
    int c;
    c = cyc;
    stall_if_cyc   = 0;
    stall_pipe_cyc = 0;
    push(1'b0, 1'b0, 32'h40,  32'h0, c + 1,       c + LAT + 2,     1'b1);
    push(1'b1, 1'b0, 32'h200, 32'h0, c + LAT + 4, c + 2 * LAT + 5, 1'b1);
    fork
      drive_d(1'b1, 1'b0, 32'h40, 32'h0);
      drive_if(32'h200);
    join
    check("s2_stall_pipe_cycles", stall_pipe_cyc, LAT + 2);
    check("s2_stall_if_cycles", stall_if_cyc, 2 * LAT + 5);
  endtask

  initial begin
    int c;
    int e0;
    int r0;
    int n;
    ref_mem[32'h100] = 32'h2402_000A;
    dut_mem[32'h100] = 32'h2402_000A;

    #1 rst = 1'b0;
    #2;
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_if_ready", {31'd0, if_ready}, 32'd0);
    check("rst_d_ready", {31'd0, d_ready}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    repeat (3) tick();
    rst   = 1'b1;
    sb_on = 1'b1;
    tick();

    // Single instruction fetch.
    c = cyc;
    stall_if_cyc = 0;
    push(1'b1, 1'b0, 32'h100, 32'h0, c + 1, c + LAT + 2, 1'b1);
    drive_if(32'h100);
    check("t1_stall_if_cycles", stall_if_cyc, LAT + 2);
    tick();
    check("t1_if_rdata_hold", if_rdata, 32'h2402_000A);

    run_scen2();
    tick();

    // Write, held through its ready cycle: exactly one mem_en.
    c  = cyc;
    e0 = en_cnt;
    push(1'b0, 1'b1, 32'h8, 32'hDEAD_BEEF, c + 1, c + 2, 1'b1);
    drive_d(1'b0, 1'b1, 32'h8, 32'hDEAD_BEEF);
    repeat (3) tick();
    check("t3_single_en", en_cnt - e0, 32'd1);

    // Read back the written word.
    c = cyc;
    push(1'b0, 1'b0, 32'h8, 32'h0, c + 1, c + LAT + 2, 1'b1);
    drive_d(1'b1, 1'b0, 32'h8, 32'h0);
    tick();

    // d_re and d_we together behave as a write.
    c = cyc;
    push(1'b0, 1'b1, 32'h10, 32'h1234_5678, c + 1, c + 2, 1'b1);
    drive_d(1'b1, 1'b1, 32'h10, 32'h1234_5678);
    tick();

    // Held write request: back-to-back writes three cycles apart.
    c = cyc;
    push(1'b0, 1'b1, 32'h20, 32'hA5A5_0F0F, c + 1, c + 2, 1'b1);
    push(1'b0, 1'b1, 32'h20, 32'hA5A5_0F0F, c + 4, c + 5, 1'b1);
    d_we    = 1'b1;
    d_addr  = 32'h20;
    d_wdata = 32'hA5A5_0F0F;
    n = 0;
    for (int i = 0; i < 40 && n < 2; i++) begin
      tick();
      if (d_ready) n++;
    end
    check("b2b_ready_count", n, 32'd2);
    tick();
    d_we = 1'b0;
    tick();

    // Reset asserted while a read sits in WAIT.
    c = cyc;
    push(1'b0, 1'b0, 32'h44, 32'h0, c + 1, 0, 1'b0);
    d_re   = 1'b1;
    d_addr = 32'h44;
    tick();
    tick();
    #2;
    rst  = 1'b0;
    d_re = 1'b0;
    #1;
    check("t4_mem_en", {31'd0, mem_en}, 32'd0);
    check("t4_mem_we", {31'd0, mem_we}, 32'd0);
    check("t4_mem_addr", mem_addr, 32'd0);
    check("t4_mem_wdata", mem_wdata, 32'd0);
    check("t4_if_rdata", if_rdata, 32'd0);
    check("t4_d_rdata", d_rdata, 32'd0);
    check("t4_ready", {30'd0, if_ready, d_ready}, 32'd0);
    check("t4_stall", {30'd0, stall_if, stall_pipe}, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    e0 = en_cnt;
    r0 = rdy_cnt;
    repeat (8) tick();
    check("t4_no_en_after_rst", en_cnt - e0, 32'd0);
    check("t4_no_ready_after_rst", rdy_cnt - r0, 32'd0);
    check("t4_d_rdata_kept", d_rdata, 32'd0);

`ifdef MEM_ARB_PERF_EN
    reset_dut();
    check("perf_rst_if", {16'd0, if_wait_cnt}, 32'd0);
    check("perf_rst_d", {16'd0, d_wait_cnt}, 32'd0);
    run_scen2();
    check("perf_d_wait_cnt", {16'd0, d_wait_cnt}, 32'd4);
    check("perf_if_wait_cnt", {16'd0, if_wait_cnt}, 32'd9);
    // IF starves behind a permanently held data read, so stall_if never
    // drops; stall_pipe is high four cycles out of every LAT+3.
    sb_on   = 1'b0;
    if_addr = 32'h200;
    d_addr  = 32'h40;
    if_req  = 1'b1;
    d_re    = 1'b1;
    repeat (84000) tick();
    check("perf_if_sat", {16'd0, if_wait_cnt}, 32'h0000_FFFF);
    check("perf_d_sat", {16'd0, d_wait_cnt}, 32'h0000_FFFF);
    if_req = 1'b0;
    d_re   = 1'b0;
    reset_dut();
    sb_on = 1'b1;
`endif

    repeat (4) tick();
    check("sb_en_q_empty", en_q.size(), 32'd0);
    check("sb_rdy_q_empty", rdy_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
